// File: rtl/id_ex_elastic_reg.sv
// ID->EX elastic pipeline register: DEPTH-entry circular queue with valid/ready on both sides.
// Define ID_EX_OCCUPANCY_EN to expose the occupancy count and a sticky dropped-offer flag.
module id_ex_elastic_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 9,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        hazard,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_pc,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [DATA_W-1:0]           in_val_rn,
    input  logic [DATA_W-1:0]           in_val_rm,
    input  logic                        in_imm,
    input  logic [11:0]                 in_shift_operand,
    input  logic [23:0]                 in_signed_imm_24,
    input  logic [3:0]                  in_dest,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_pc,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [DATA_W-1:0]           out_val_rn,
    output logic [DATA_W-1:0]           out_val_rm,
    output logic                        out_imm,
    output logic [11:0]                 out_shift_operand,
    output logic [23:0]                 out_signed_imm_24,
    output logic [3:0]                  out_dest
`ifdef ID_EX_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic                        overflow_sticky
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [3:0]        dest;
    } entry_t;

    entry_t            storage [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    entry_t            in_entry;
    entry_t            out_entry;
    logic              push;
    logic              pop;

    assign in_entry = '{pc: in_pc, ctrl: in_ctrl, val_rn: in_val_rn, val_rm: in_val_rm,
                        imm: in_imm, shift_operand: in_shift_operand,
                        signed_imm_24: in_signed_imm_24, dest: in_dest};

    assign in_ready  = rst & ~hazard & (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Empty queue presents all-zero fields so EX sees a bubble (ctrl=0).
    assign out_entry         = out_valid ? storage[rd_ptr] : '0;
    assign out_pc            = out_entry.pc;
    assign out_ctrl          = out_entry.ctrl;
    assign out_val_rn        = out_entry.val_rn;
    assign out_val_rm        = out_entry.val_rm;
    assign out_imm           = out_entry.imm;
    assign out_shift_operand = out_entry.shift_operand;
    assign out_signed_imm_24 = out_entry.signed_imm_24;
    assign out_dest          = out_entry.dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= in_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ID_EX_OCCUPANCY_EN
    assign occupancy = count;

    // Offer refused for lack of space (not because of a hazard) is remembered until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_sticky <= 1'b0;
        end else if (in_valid & ~in_ready & ~hazard) begin
            overflow_sticky <= 1'b1;
        end
    end
`endif

endmodule
